// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter for the Tomasulo core: picks one completed
// functional-unit result per cycle, round-robin, and broadcasts it registered.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_FU-1:0]        req_valid,
    input  logic [NUM_FU*TAG_W-1:0]  req_tag,
    input  logic [NUM_FU*DATA_W-1:0] req_data,
    output logic [NUM_FU-1:0]        grant,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] elig;
    logic              found;
    logic [PTR_W-1:0]  win;
    logic [PTR_W:0]    cand;
    logic [PTR_W-1:0]  ptr_next;
    logic [NUM_FU-1:0] grant_next;
    logic [TAG_W-1:0]  tag_next;
    logic [DATA_W-1:0] data_next;

    // A unit still holds its request during its own broadcast; mask it.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            elig[i] = req_valid[i]
                   && (req_tag[i*TAG_W +: TAG_W] != '0)
                   && !(cdb_valid && grant[i]);
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(j);
            if (cand >= (PTR_W+1)'(NUM_FU)) begin
                cand = cand - (PTR_W+1)'(NUM_FU);
            end
            if (!found && elig[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant_next = '0;
        tag_next   = '0;
        data_next  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (win == PTR_W'(i)) begin
                grant_next[i] = 1'b1;
                tag_next      = req_tag[i*TAG_W +: TAG_W];
                data_next     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_next = win + PTR_W'(1);
        if (win == PTR_W'(NUM_FU - 1)) begin
            ptr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            grant     <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else if (found) begin
            rr_ptr    <= ptr_next;
            grant     <= grant_next;
            cdb_valid <= 1'b1;
            cdb_tag   <= tag_next;
            cdb_data  <= data_next;
        end else begin
            grant     <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed protocol scenarios plus randomized
// traffic, all checked against a cycle-level reference model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_grant;
    int          m_ptr;

    // functional-unit behaviour
    bit auto_m[N];
    bit drop_pend[N];
    int wait_cnt[N];

    cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_tag(req_tag),
        .req_data(req_data),
        .grant(grant),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_unit(int i, bit v, logic [TW-1:0] t, logic [DW-1:0] d);
        req_valid[i]        = v;
        req_tag[i*TW +: TW] = t;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic model_clear();
        m_valid = 0;
        m_tag   = '0;
        m_data  = '0;
        m_grant = '0;
        m_ptr   = 0;
    endtask

    task automatic chk_outputs(string pfx);
        chk({pfx, "_valid"}, 64'(cdb_valid), 64'(m_valid));
        chk({pfx, "_tag"},   64'(cdb_tag),   64'(m_tag));
        chk({pfx, "_data"},  64'(cdb_data),  64'(m_data));
        chk({pfx, "_grant"}, 64'(grant),     64'(m_grant));
    endtask

    // One clock: predict from the inputs held across the edge, then compare.
    task automatic tick(string pfx);
        bit          found = 0;
        int          k = 0;
        bit          n_valid;
        logic [TW-1:0] n_tag;
        logic [DW-1:0] n_data;
        logic [N-1:0]  n_grant;
        int          n_ptr;
        for (int j = 0; j < N; j++) begin
            int c = (m_ptr + j) % N;
            if (!found && req_valid[c]
                && req_tag[c*TW +: TW] != '0
                && !(m_valid && m_grant[c])) begin
                found = 1;
                k = c;
            end
        end
        if (found) begin
            n_valid = 1;
            n_tag   = req_tag[k*TW +: TW];
            n_data  = req_data[k*DW +: DW];
            n_grant = N'(1) << k;
            n_ptr   = (k + 1) % N;
        end else begin
            n_valid = 0;
            n_tag   = '0;
            n_data  = m_data;
            n_grant = '0;
            n_ptr   = m_ptr;
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            model_clear();
        end else begin
            m_valid = n_valid;
            m_tag   = n_tag;
            m_data  = n_data;
            m_grant = n_grant;
            m_ptr   = n_ptr;
        end
        chk_outputs(pfx);
        for (int i = 0; i < N; i++) begin
            if (drop_pend[i]) begin
                req_valid[i] = 1'b0;
                drop_pend[i] = 0;
            end else if (auto_m[i] && m_grant[i]) begin
                drop_pend[i] = 1;
            end
        end
    endtask

    task automatic reset_pulse(string pfx);
        reset = 1'b0;
        #1;
        model_clear();
        chk_outputs(pfx);
        for (int i = 0; i < N; i++) drop_pend[i] = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic clear_units();
        for (int i = 0; i < N; i++) begin
            set_unit(i, 0, '0, '0);
            drop_pend[i] = 0;
            auto_m[i] = 1;
        end
    endtask

    initial begin
        int cnt;
        int bad;
        reset = 1'b0;
        req_valid = '0;
        req_tag = '0;
        req_data = '0;
        model_clear();
        for (int i = 0; i < N; i++) begin
            auto_m[i] = 1;
            drop_pend[i] = 0;
            wait_cnt[i] = 0;
        end
        #1;
        chk_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick("idle");

        // single request
        set_unit(2, 1, 4'd5, 32'hDEADBEEF);
        tick("t1a");
        chk("t1_tag", 64'(cdb_tag), 64'd5);
        chk("t1_data", 64'(cdb_data), 64'hDEADBEEF);
        chk("t1_grant", 64'(grant), 64'b0100);
        tick("t1b");
        chk("t1_valid_off", 64'(cdb_valid), 64'd0);
        tick("t1c");

        // simultaneous requests from pointer 0
        reset_pulse("rst2");
        set_unit(0, 1, 4'd1, 32'h11);
        set_unit(1, 1, 4'd2, 32'h22);
        set_unit(3, 1, 4'd3, 32'h33);
        tick("t2a");
        chk("t2_tag1", 64'(cdb_tag), 64'd1);
        tick("t2b");
        chk("t2_tag2", 64'(cdb_tag), 64'd2);
        tick("t2c");
        chk("t2_tag3", 64'(cdb_tag), 64'd3);
        tick("t2d");
        tick("t2e");
        clear_units();

        // rotation between two always-busy units
        auto_m[0] = 0;
        auto_m[3] = 0;
        set_unit(0, 1, 4'd8, $urandom);
        set_unit(3, 1, 4'd9, $urandom);
        for (int r = 0; r < 4; r++) begin
            tick("t3");
            chk("t3_grant", 64'(grant), (r % 2 == 0) ? 64'b0001 : 64'b1000);
            req_data[0 +: DW] = $urandom;
            req_data[3*DW +: DW] = $urandom;
        end
        clear_units();
        tick("t3z");
        tick("t3z");

        // no duplicate broadcast for multiplier-style timing
        set_unit(1, 1, 4'd6, 32'h600D);
        cnt = 0;
        for (int r = 0; r < 4; r++) begin
            tick("t4");
            if (cdb_valid && cdb_tag == 4'd6) cnt++;
        end
        chk("t4_once", 64'(cnt), 64'd1);
        clear_units();

        // tag-0 request ignored
        set_unit(0, 1, 4'd0, 32'hBAD);
        set_unit(1, 1, 4'd7, 32'h777);
        cnt = 0;
        bad = 0;
        for (int r = 0; r < 5; r++) begin
            tick("t5");
            if (cdb_valid && cdb_tag == 4'd7) cnt++;
            if (grant[0]) bad++;
        end
        chk("t5_tag7_once", 64'(cnt), 64'd1);
        chk("t5_unit0_never", 64'(bad), 64'd0);
        clear_units();
        tick("t5z");

        // reset mid-broadcast
        set_unit(2, 1, 4'd10, 32'hA0A0);
        set_unit(3, 1, 4'd12, 32'hC0C0);
        tick("t6a");
        chk("t6_busy", 64'(cdb_valid), 64'd1);
        reset_pulse("t6rst");
        tick("t6b");
        chk("t6_regrant", 64'(grant), 64'b0100);
        chk("t6_tag", 64'(cdb_tag), 64'd10);
        for (int r = 0; r < 3; r++) tick("t6c");
        clear_units();
        tick("t6z");

        // random units obeying the clear-on-broadcast protocol
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && !drop_pend[i]
                    && $urandom_range(0, 2) == 0) begin
                    set_unit(i, 1, TW'($urandom_range(1, 15)), $urandom);
                    wait_cnt[i] = 0;
                end
            end
            tick("rp");
            for (int i = 0; i < N; i++) begin
                if (cdb_valid && grant[i]) begin
                    chk("fair", 64'(wait_cnt[i] <= N - 1), 64'd1);
                end else if (cdb_valid && req_valid[i] && !drop_pend[i]) begin
                    wait_cnt[i]++;
                end
            end
        end
        clear_units();
        tick("rpz");

        // unconstrained random inputs with occasional resets
        for (int r = 0; r < 200; r++) begin
            for (int i = 0; i < N; i++) begin
                auto_m[i] = 0;
                set_unit(i, bit'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? '0
                                                     : TW'($urandom),
                         $urandom);
            end
            if ($urandom_range(0, 49) == 0) reset_pulse("rr_rst");
            else tick("rr");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
